regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised general-purpose register file for the pipelined MIPS core, with a per-register busy scoreboard for hazard detection. It provides two read ports and one write port with write-to-read bypass, a hardwired zero register, and an optional registered-read mode. It sits between decode (read and issue) and writeback (write and busy clear), and replaces the fixed 32×32 register file.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2^ADDR_W registers
- READ_REG, 0, 0 = combinational read; 1 = read data captured on rising clock edge
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- Rest  in  1  asynchronous reset, active-low; clears every register and every busy bit
- rd_en  in  1  read enable for both read ports
- a_addr  in  ADDR_W  read port A address
- b_addr  in  ADDR_W  read port B address
- a_data  out  DATA_W  read port A data
- b_data  out  DATA_W  read port B data
- wr_en  in  1  writeback enable
- d_addr  in  ADDR_W  writeback address
- writeback_data  in  DATA_W  writeback value
- iss_en  in  1  issue: marks iss_addr busy (pending producer)
- iss_addr  in  ADDR_W  destination address of the issuing instruction
- flush  in  1  synchronous clear of all busy bits (pipeline squash)
- a_busy  out  1  register at a_addr has a pending write
- b_busy  out  1  register at b_addr has a pending write
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data, combinational, no bypass, ignores rd_en

## Operation
- Storage: 2^ADDR_W × DATA_W flops, plus a 2^ADDR_W-bit busy vector.
- Write: on rising edge with wr_en=1, reg[d_addr] ← writeback_data.
  - If ZERO_REG=1 and d_addr=0, the write is dropped.
- Bypass (per port X ∈ {a,b}):
  - Condition: wr_en=1, d_addr=X_addr, and the address is writable.
  - Effect: the read value is writeback_data instead of the stored value.
- Read, READ_REG=0:
  - X_data = bypassed or stored value when rd_en=1.
  - X_data = 0 when rd_en=0.
- Read, READ_REG=1:
  - X_data registered on the rising edge when rd_en=1, using the bypassed value.
  - Holds its last value when rd_en=0.
- Busy vector, next state per edge:
  - Priority: flush (all bits → 0) > iss_en set of busy[iss_addr] > wr_en clear of busy[d_addr].
  - If iss_en and wr_en target the same address in one cycle, busy stays 1 (new producer).
  - iss_addr=0 is ignored when ZERO_REG=1.
- Busy outputs, combinational:
  - X_busy = busy[X_addr] & ~(wr_en & d_addr=X_addr).
  - Same-cycle writeback is forwarded, so no stall is reported.
  - X_busy is forced to 0 for address 0 when ZERO_REG=1.
  - Independent of rd_en and READ_REG.
- Reading an address with busy=1 and no same-cycle writeback returns the stale stored value; the stall decision belongs to decode.

## Timing
- Reset (Rest=0, asynchronous):
  - All registers = 0 and all busy bits = 0.
  - a_data and b_data = 0 (both modes); a_busy and b_busy = 0; dbg_data = 0.
  - Registers are held while Rest=0; release is synchronous to the next rising edge.
- Latency:
  - READ_REG=0: read data valid in the same cycle as the address.
  - READ_REG=1: read data valid one cycle after the address and rd_en.
  - Write visible through the stored path on the cycle after the edge; visible through bypass in the same cycle.
- busy set by iss_en is visible on a_busy/b_busy the cycle after the issue edge.
- Reset asserted mid-write: the write is lost and the register reads 0.
- dbg_data reflects stored contents only; a write appears the cycle after its edge.

## Test plan
- Reset then read: Rest=0, then release, rd_en=1, a_addr=5, b_addr=31 → a_data=0, b_data=0, a_busy=b_busy=0.
- Zero register: wr_en=1, d_addr=0, data=0xDEADBEEF; iss_en=1, iss_addr=0 → a_addr=0 reads 0, a_busy=0, dbg_data(0)=0.
- Bypass: write 0x12345678 to r7 while a_addr=b_addr=7 → same cycle a_data=b_data=0x12345678 (READ_REG=0); next cycle with READ_REG=1 both show 0x12345678.
- Scoreboard: iss r9 → next cycle a_busy=1 for a_addr=9; writeback r9 with 0xA5A5A5A5 → a_busy=0 in that cycle and a_data=0xA5A5A5A5; busy[9]=0 afterwards.
- Simultaneous issue/writeback: iss_en and wr_en both at r3 → next cycle busy[3]=1; flush asserted together with iss r4 → next cycle every busy bit=0.
- Parameter sweep (DATA_W=16, ADDR_W=3): write 0xFFFF to r7, read back 0xFFFF; rd_en=0 → outputs 0 (READ_REG=0) or held (READ_REG=1).

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass and a per-register
// busy scoreboard used by decode for hazard detection.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_REG = 0,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              Rest,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] writeback_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush,
    output logic              a_busy,
    output logic              b_busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;

    logic wr_ok;
    logic iss_ok;
    logic a_fwd;
    logic b_fwd;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;

    assign wr_ok  = wr_en  && !(ZR && d_addr == '0);
    assign iss_ok = iss_en && !(ZR && iss_addr == '0);

    always_ff @(posedge clock or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            if (wr_ok) begin
                regs_reg[d_addr] <= writeback_data;
            end
            busy_reg <= busy_next;
        end
    end

    // Later assignments win: flush over issue over writeback clear.
    always_comb begin
        busy_next = busy_reg;
        if (wr_en) begin
            busy_next[d_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
    end

    assign a_fwd = wr_ok && (d_addr == a_addr);
    assign b_fwd = wr_ok && (d_addr == b_addr);
    assign a_val = a_fwd ? writeback_data : regs_reg[a_addr];
    assign b_val = b_fwd ? writeback_data : regs_reg[b_addr];

    // A same-cycle writeback is forwarded, so it never reports a stall.
    assign a_busy = busy_reg[a_addr] && !(wr_en && d_addr == a_addr)
                    && !(ZR && a_addr == '0);
    assign b_busy = busy_reg[b_addr] && !(wr_en && d_addr == b_addr)
                    && !(ZR && b_addr == '0);

    assign dbg_data = regs_reg[dbg_addr];

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] a_q_reg;
            logic [DATA_W-1:0] b_q_reg;

            always_ff @(posedge clock or negedge Rest) begin
                if (!Rest) begin
                    a_q_reg <= '0;
                    b_q_reg <= '0;
                end else if (rd_en) begin
                    a_q_reg <= a_val;
                    b_q_reg <= b_val;
                end
            end

            assign a_data = a_q_reg;
            assign b_data = b_q_reg;
        end else begin : g_rd_comb
            assign a_data = rd_en ? a_val : '0;
            assign b_data = rd_en ? b_val : '0;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: combinational and registered read variants at 32x32, plus a
// 16-bit/8-entry pair, driven in lockstep and checked against hand-computed values.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Rest;
    logic        rd_en, wr_en, iss_en, flush;
    logic [4:0]  a_addr, b_addr, d_addr, iss_addr, dbg_addr;
    logic [31:0] writeback_data;
    logic [31:0] ac_data, bc_data, ar_data, br_data, dbgc_data, dbgr_data;
    logic        ac_busy, bc_busy, ar_busy, br_busy;

    logic        s_rd_en, s_wr_en, s_iss_en, s_flush;
    logic [2:0]  s_a_addr, s_b_addr, s_d_addr, s_iss_addr, s_dbg_addr;
    logic [15:0] s_wdata;
    logic [15:0] sc_a, sc_b, sr_a, sr_b, sc_dbg, sr_dbg;
    logic        sc_ab, sc_bb, sr_ab, sr_bb;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .READ_REG(0), .ZERO_REG(1)) u_comb (
        .clock(clk), .Rest(Rest), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
        .a_data(ac_data), .b_data(bc_data), .wr_en(wr_en), .d_addr(d_addr),
        .writeback_data(writeback_data), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .a_busy(ac_busy), .b_busy(bc_busy), .dbg_addr(dbg_addr),
        .dbg_data(dbgc_data));

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .READ_REG(1), .ZERO_REG(1)) u_reg (
        .clock(clk), .Rest(Rest), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
        .a_data(ar_data), .b_data(br_data), .wr_en(wr_en), .d_addr(d_addr),
        .writeback_data(writeback_data), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .a_busy(ar_busy), .b_busy(br_busy), .dbg_addr(dbg_addr),
        .dbg_data(dbgr_data));

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .READ_REG(0), .ZERO_REG(1)) u_small_comb (
        .clock(clk), .Rest(Rest), .rd_en(s_rd_en), .a_addr(s_a_addr), .b_addr(s_b_addr),
        .a_data(sc_a), .b_data(sc_b), .wr_en(s_wr_en), .d_addr(s_d_addr),
        .writeback_data(s_wdata), .iss_en(s_iss_en), .iss_addr(s_iss_addr),
        .flush(s_flush), .a_busy(sc_ab), .b_busy(sc_bb), .dbg_addr(s_dbg_addr),
        .dbg_data(sc_dbg));

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .READ_REG(1), .ZERO_REG(1)) u_small_reg (
        .clock(clk), .Rest(Rest), .rd_en(s_rd_en), .a_addr(s_a_addr), .b_addr(s_b_addr),
        .a_data(sr_a), .b_data(sr_b), .wr_en(s_wr_en), .d_addr(s_d_addr),
        .writeback_data(s_wdata), .iss_en(s_iss_en), .iss_addr(s_iss_addr),
        .flush(s_flush), .a_busy(sr_ab), .b_busy(sr_bb), .dbg_addr(s_dbg_addr),
        .dbg_data(sr_dbg));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Rest = 1'b0; rd_en = 1'b1; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
        a_addr = 5'd5; b_addr = 5'd31; d_addr = '0; iss_addr = '0; dbg_addr = '0;
        writeback_data = '0;
        s_rd_en = 1'b0; s_wr_en = 1'b0; s_iss_en = 1'b0; s_flush = 1'b0;
        s_a_addr = '0; s_b_addr = '0; s_d_addr = '0; s_iss_addr = '0; s_dbg_addr = '0;
        s_wdata = '0;
        tick(); tick();
        check("rst_ar", ar_data, 32'h0);
        check("rst_dbg", dbgc_data, 32'h0);
        Rest = 1'b1;

        // Reset then read
        #1;
        check("rst_ac", ac_data, 32'h0);
        check("rst_bc", bc_data, 32'h0);
        check("rst_abusy", {31'b0, ac_busy}, 32'h0);
        check("rst_bbusy", {31'b0, bc_busy}, 32'h0);
        tick();
        check("rst_br", br_data, 32'h0);

        // Zero register ignores writes and issues
        wr_en = 1'b1; d_addr = 5'd0; writeback_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd0; a_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        check("z_ac_nobyp", ac_data, 32'h0);
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        check("z_ac", ac_data, 32'h0);
        check("z_ar", ar_data, 32'h0);
        check("z_abusy", {31'b0, ac_busy}, 32'h0);
        check("z_dbg", dbgc_data, 32'h0);

        // Bypass on r7
        wr_en = 1'b1; d_addr = 5'd7; writeback_data = 32'h12345678;
        a_addr = 5'd7; b_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        check("byp_ac", ac_data, 32'h12345678);
        check("byp_bc", bc_data, 32'h12345678);
        check("byp_dbg_old", dbgc_data, 32'h0);
        tick();
        wr_en = 1'b0;
        check("byp_ar", ar_data, 32'h12345678);
        check("byp_br", br_data, 32'h12345678);
        #1;
        check("byp_dbg_new", dbgc_data, 32'h12345678);
        check("stored_ac", ac_data, 32'h12345678);

        // Scoreboard on r9
        iss_en = 1'b1; iss_addr = 5'd9; a_addr = 5'd9;
        #1;
        check("sb_before", {31'b0, ac_busy}, 32'h0);
        tick();
        iss_en = 1'b0;
        #1;
        check("sb_set_c", {31'b0, ac_busy}, 32'h1);
        check("sb_set_r", {31'b0, ar_busy}, 32'h1);
        check("sb_stale", ac_data, 32'h0);
        wr_en = 1'b1; d_addr = 5'd9; writeback_data = 32'hA5A5A5A5;
        #1;
        check("sb_fwd_busy", {31'b0, ac_busy}, 32'h0);
        check("sb_fwd_data", ac_data, 32'hA5A5A5A5);
        tick();
        wr_en = 1'b0;
        #1;
        check("sb_clr", {31'b0, ac_busy}, 32'h0);
        check("sb_ar", ar_data, 32'hA5A5A5A5);

        // Issue and writeback on the same address keeps busy set
        iss_en = 1'b1; iss_addr = 5'd3; wr_en = 1'b1; d_addr = 5'd3;
        writeback_data = 32'h00000033; a_addr = 5'd3; b_addr = 5'd4;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        check("iw_busy", {31'b0, ac_busy}, 32'h1);
        check("iw_data", ac_data, 32'h00000033);

        // Flush wins over a concurrent issue
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        flush = 1'b0; iss_en = 1'b0;
        #1;
        check("fl_a", {31'b0, ac_busy}, 32'h0);
        check("fl_b", {31'b0, bc_busy}, 32'h0);
        check("fl_b_r", {31'b0, br_busy}, 32'h0);

        // rd_en=0: zero in combinational mode, hold in registered mode
        a_addr = 5'd7; b_addr = 5'd9;
        tick();
        rd_en = 1'b0; a_addr = 5'd3; b_addr = 5'd4;
        #1;
        check("rd0_ac", ac_data, 32'h0);
        check("rd0_bc", bc_data, 32'h0);
        tick();
        check("rd0_ar_hold", ar_data, 32'h12345678);
        check("rd0_br_hold", br_data, 32'hA5A5A5A5);

        // Reset asserted mid-write loses the write
        rd_en = 1'b1; wr_en = 1'b1; d_addr = 5'd12; writeback_data = 32'h0000CAFE;
        a_addr = 5'd12; dbg_addr = 5'd12;
        #2;
        Rest = 1'b0;
        #1;
        check("mr_ar", ar_data, 32'h0);
        tick();
        wr_en = 1'b0;
        Rest = 1'b1;
        #1;
        check("mr_dbg", dbgc_data, 32'h0);
        check("mr_ac", ac_data, 32'h0);
        dbg_addr = 5'd7;
        #1;
        check("mr_r7", dbgr_data, 32'h0);

        // 16-bit, 8-entry variants
        s_rd_en = 1'b1; s_wr_en = 1'b1; s_d_addr = 3'd7; s_wdata = 16'hFFFF;
        s_a_addr = 3'd7; s_b_addr = 3'd0; s_dbg_addr = 3'd7;
        tick();
        s_wr_en = 1'b0;
        #1;
        check("s_ac", {16'h0, sc_a}, 32'h0000FFFF);
        check("s_ar", {16'h0, sr_a}, 32'h0000FFFF);
        check("s_dbg", {16'h0, sc_dbg}, 32'h0000FFFF);
        s_rd_en = 1'b0; s_a_addr = 3'd1;
        #1;
        check("s_rd0_ac", {16'h0, sc_a}, 32'h0);
        tick();
        check("s_rd0_ar", {16'h0, sr_a}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
